// File: rtl/xdma_byp_pkg.sv
// Shared constants and types for the XDMA descriptor-bypass issuer:
// control/status bit positions, the descriptor record and the FSM encoding.
package xdma_byp_pkg;

  localparam int CTL_STOP      = 0;
  localparam int CTL_COMPLETED = 1;
  localparam int CTL_EOP       = 4;

  localparam int STS_BUSY      = 0;
  localparam int STS_STOPPED   = 1;
  localparam int STS_ALIGN_ERR = 3;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [27:0] len;
    logic [15:0] ctl;
  } byp_dsc_t;

  typedef enum logic {ST_IDLE, ST_ISSUE} byp_state_t;

  // STOP and COMPLETED mark the final chunk of a request; EOP only if requested.
  function automatic logic [15:0] dsc_ctl(input logic last, input logic eop);
    logic [15:0] c;
    c                = '0;
    c[CTL_STOP]      = last;
    c[CTL_COMPLETED] = last;
    c[CTL_EOP]       = last & eop;
    return c;
  endfunction

endpackage

// File: rtl/xdma_dsc_byp_issuer.sv
// Splits whole-transfer requests into MAX_CHUNK-sized XDMA bypass descriptors
// and issues them on the dsc_byp ready/load handshake, at most one per two cycles.
module xdma_dsc_byp_issuer
  import xdma_byp_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 28,
  parameter int REQ_LEN_W = 32,
  parameter int MAX_CHUNK = 4096,
  parameter int CNT_W     = 16
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_src_addr,
  input  logic [ADDR_W-1:0]    req_dst_addr,
  input  logic [REQ_LEN_W-1:0] req_len,
  input  logic                 req_eop,
  input  logic                 dsc_byp_ready,
  output logic                 dsc_byp_load,
  output logic [ADDR_W-1:0]    dsc_byp_src_addr,
  output logic [ADDR_W-1:0]    dsc_byp_dst_addr,
  output logic [LEN_W-1:0]     dsc_byp_len,
  output logic [15:0]          dsc_byp_ctl,
  input  logic [7:0]           dma_sts,
  output logic                 busy,
  output logic [CNT_W-1:0]     dsc_issued,
  output logic                 req_done,
  output logic                 err_zero_len,
  output logic                 err_sts
);

  byp_state_t           state;
  logic [ADDR_W-1:0]    cur_src;
  logic [ADDR_W-1:0]    cur_dst;
  logic [REQ_LEN_W-1:0] remaining;
  logic                 eop_flag;
  logic                 issued_any;

  logic [LEN_W-1:0]     chunk;
  logic [ADDR_W-1:0]    chunk_addr;
  logic                 last_chunk;
  logic                 accept;
  logic                 issue;
  logic                 unused_sts;

  function automatic logic [LEN_W-1:0] chunk_of(input logic [REQ_LEN_W-1:0] rem);
    if (rem < REQ_LEN_W'(MAX_CHUNK))
      return LEN_W'(rem);
    else
      return LEN_W'(MAX_CHUNK);
  endfunction

  assign chunk      = chunk_of(remaining);
  assign chunk_addr = ADDR_W'(chunk);
  assign last_chunk = (remaining <= REQ_LEN_W'(MAX_CHUNK));
  assign accept     = (state == ST_IDLE) && req_valid && req_ready;
  // A fresh load is only raised from a load-free cycle, giving the 1-in-2 cadence.
  assign issue      = (state == ST_ISSUE) && !dsc_byp_load && dsc_byp_ready
                      && (remaining != '0);
  assign unused_sts = ^{dma_sts[7:4], dma_sts[2], dma_sts[STS_STOPPED]};

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state            <= ST_IDLE;
      req_ready        <= 1'b1;
      dsc_byp_load     <= 1'b0;
      dsc_byp_src_addr <= '0;
      dsc_byp_dst_addr <= '0;
      dsc_byp_len      <= '0;
      dsc_byp_ctl      <= '0;
      remaining        <= '0;
      busy             <= 1'b0;
      dsc_issued       <= '0;
      req_done         <= 1'b0;
      err_zero_len     <= 1'b0;
      err_sts          <= 1'b0;
      issued_any       <= 1'b0;
    end else begin
      dsc_byp_load <= 1'b0;
      req_done     <= 1'b0;
      busy         <= dma_sts[STS_BUSY];

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (req_len == '0) begin
              err_zero_len <= 1'b1;
              req_done     <= 1'b1;
            end else begin
              state     <= ST_ISSUE;
              req_ready <= 1'b0;
              remaining <= req_len;
              busy      <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (dsc_byp_load && (remaining == '0)) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
          if (issue) begin
            dsc_byp_load     <= 1'b1;
            dsc_byp_src_addr <= cur_src;
            dsc_byp_dst_addr <= cur_dst;
            dsc_byp_len      <= chunk;
            dsc_byp_ctl      <= dsc_ctl(last_chunk, eop_flag);
            remaining        <= remaining - REQ_LEN_W'(chunk);
            dsc_issued       <= dsc_issued + CNT_W'(1);
            issued_any       <= 1'b1;
            req_done         <= last_chunk;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Bit 1 alone accompanies a normal COMPLETED stop; only alignment errors latch.
      if (issued_any && !dma_sts[STS_BUSY] && dma_sts[STS_ALIGN_ERR])
        err_sts <= 1'b1;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (accept) begin
      cur_src  <= req_src_addr;
      cur_dst  <= req_dst_addr;
      eop_flag <= req_eop;
    end else if (issue) begin
      cur_src <= cur_src + chunk_addr;
      cur_dst <= cur_dst + chunk_addr;
    end
  end

endmodule
